serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in 4-bit digits, legal range 2..8.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port START  input  1  request to begin one addition.
REQ-005 SHALL have port A  input  4*NIBBLES  operand A.
REQ-006 SHALL have port B  input  4*NIBBLES  operand B.
REQ-007 SHALL have port SUB  input  1  subtract select; present only with SUB_EN.
REQ-008 SHALL have port ADD_A  output  4  nibble of A to the external 4-bit adder.
REQ-009 SHALL have port ADD_B  output  4  nibble of B (or ~B) to the adder.
REQ-010 SHALL have port ADD_CIN  output  1  carry-in to the adder.
REQ-011 SHALL have port ADD_SUM  input  4  adder sum, combinational from ADD_A/ADD_B/ADD_CIN.
REQ-012 SHALL have port ADD_COUT  input  1  adder carry-out.
REQ-013 SHALL have port BUSY  output  1  high while a nibble is being added.
REQ-014 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-015 SHALL have port SUM  output  4*NIBBLES  registered result.
REQ-016 SHALL have port C_MSB  output  1  carry out of the most significant nibble.
REQ-017 SHALL have port OF_S  output  1  two's-complement overflow.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FIN.
REQ-019 In IDLE, START=1 SHALL latch A, B (and SUB) into operand registers, clear nibble index to 0, set carry register to 0 (add) or 1 (subtract), and move to RUN.
REQ-020 In RUN, ADD_A/ADD_B SHALL be nibble [index] of latched A/B (B inverted when subtracting), and ADD_CIN SHALL be the carry register.
REQ-021 Each RUN cycle SHALL write ADD_SUM into SUM nibble [index], load ADD_COUT into the carry register, and increment index.
REQ-022 The RUN cycle for index NIBBLES-1 SHALL move to FIN; FIN SHALL last exactly one cycle, then go to IDLE.
REQ-023 Latency: with START sampled at edge k, SUM, C_MSB and OF_S SHALL be final and DONE=1 in the cycle after edge k+NIBBLES.
REQ-024 BUSY SHALL be 1 only in RUN; DONE SHALL be 1 only in FIN.
REQ-025 C_MSB SHALL equal the final ADD_COUT; in subtract mode 1 means no borrow.
REQ-026 OF_S SHALL be (A_msb == B'_msb) AND (SUM_msb != A_msb), where B' is the B operand as presented to the adder.
REQ-027 START in RUN or FIN SHALL be ignored, with no queuing.
REQ-028 SUM, C_MSB and OF_S SHALL hold their values from FIN until the next accepted START, and the accepting edge SHALL not clear them.
REQ-029 In IDLE and FIN, ADD_A, ADD_B and ADD_CIN SHALL be 0.
REQ-030 Changes on A, B or SUB after acceptance SHALL not affect the operation in progress.

Reset
REQ-031 RST=1 at a clock edge SHALL force IDLE and zero SUM, C_MSB, OF_S, BUSY, DONE, index, carry and operand registers.
REQ-032 RST SHALL take priority over START, and over RUN mid-operation: the partial result is discarded and no DONE occurs.

Configuration
REQ-033 With macro SERIAL_ADD_SUB_EN defined, port SUB SHALL exist and SUB=1 SHALL compute A-B as A+~B+1.
REQ-034 Without SERIAL_ADD_SUB_EN, port SUB SHALL be absent, and the block SHALL add only, with initial carry 0.

Verification (NIBBLES=4)
REQ-035 START with A=0x00FF, B=0x0001 -> BUSY for 4 cycles, DONE 5 cycles after START, SUM=0x0100, C_MSB=0, OF_S=0.
REQ-036 A=0x7FFF, B=0x0001 -> SUM=0x8000, OF_S=1, C_MSB=0; A=0xFFFF, B=0x0001 -> SUM=0x0000, C_MSB=1, OF_S=0.
REQ-037 SERIAL_ADD_SUB_EN, SUB=1, A=0x0005, B=0x0007 -> SUM=0xFFFE, C_MSB=0, OF_S=0; A=0x8000, B=0x0001 -> SUM=0x7FFF, OF_S=1.
REQ-038 START held high through an operation -> second operation is accepted only in the IDLE cycle after DONE; no START edge in RUN or FIN is captured.
REQ-039 RST asserted on the 2nd RUN cycle -> next cycle IDLE, all outputs 0, no DONE pulse; a new START then completes normally.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: multi-digit adder that reuses one external 4-bit adder.
// It feeds the operands through the adder one nibble per cycle, least
// significant nibble first, and chains the carry between nibbles.
// Result, carry-out and signed overflow are registered and held until the
// next accepted START.
// Optional build macro SERIAL_ADD_SUB_EN adds the SUB port. With SUB=1 the
// block computes A-B as A + ~B + 1. Without the macro it only adds.
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                 SUB,
`endif
  output logic [3:0]           ADD_A,
  output logic [3:0]           ADD_B,
  output logic                 ADD_CIN,
  input  logic [3:0]           ADD_SUM,
  input  logic                 ADD_COUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 C_MSB,
  output logic                 OF_S
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               sub_q;
  logic               sub_in;
  logic [IDX_W+1:0]   nib_base;
  logic               last_nib;

  // Signed overflow: both operand signs agree and the result sign differs.
  function automatic logic ovf(input logic a_msb, input logic b_msb,
                               input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = SUB;
`else
  assign sub_in = 1'b0;
`endif

  assign nib_base = {idx, 2'b00};
  assign last_nib = (idx == IDX_W'(NIBBLES - 1));

  // Drive the external adder with the current nibble only while running.
  always_comb begin
    ADD_A   = 4'h0;
    ADD_B   = 4'h0;
    ADD_CIN = 1'b0;
    if (state == RUN) begin
      ADD_A   = op_a[nib_base +: 4];
      ADD_B   = op_b[nib_base +: 4] ^ {4{sub_q}};
      ADD_CIN = carry;
    end
  end

  // Control FSM plus the nibble-serial result accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sub_q <= 1'b0;
      SUM   <= '0;
      C_MSB <= 1'b0;
      OF_S  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            // Previous SUM/C_MSB/OF_S stay visible until overwritten.
            op_a  <= A;
            op_b  <= B;
            sub_q <= sub_in;
            idx   <= '0;
            carry <= sub_in;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          SUM[nib_base +: 4] <= ADD_SUM;
          carry              <= ADD_COUT;
          idx                <= idx + 1'b1;
          if (last_nib) begin
            C_MSB <= ADD_COUT;
            OF_S  <= ovf(op_a[W-1], op_b[W-1] ^ sub_q, ADD_SUM[3]);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: bench for serial_add_ctrl with NIBBLES=4.
// It models the external 4-bit adder, applies a directed vector table and
// randomized operations checked against an arithmetic reference model, and
// adds hand sequences for START held high and reset in mid-operation.
module tb_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         sub = 1'b0;
  logic [3:0]   ADD_A, ADD_B, ADD_SUM;
  logic         ADD_CIN, ADD_COUT;
  logic         BUSY, DONE, C_MSB, OF_S;
  logic [W-1:0] SUM;

  int total = 0;
  int bad = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_c = 1'b0;
  logic         prev_of = 1'b0;

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
`ifdef SERIAL_ADD_SUB_EN
    .SUB(sub),
`endif
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
    .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .C_MSB(C_MSB), .OF_S(OF_S)
  );

  // External 4-bit adder.
  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'h0, ADD_CIN};

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         c;
    logic         of;
    string        nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-word arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] sum,
                                output logic c, output logic of);
    longint ua, ub, sa, sb, r, sd;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sd = sa - sb;
    end else begin
      r  = ua + ub;
      c  = r[W];
      sd = sa + sb;
    end
    sum = r[W-1:0];
    of  = (sd > (longint'(1) <<< (W-1)) - 1) || (sd < -(longint'(1) <<< (W-1)));
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] esum, input logic ec, input logic eof,
                       input string nm);
    logic [3:0] eb;
    @(negedge CLK);
    A = a; B = b; sub = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
    chk({nm, ".hold_sum"}, 32'(SUM), 32'(prev_sum));
    chk({nm, ".hold_c"}, 32'(C_MSB), 32'(prev_c));
    chk({nm, ".hold_of"}, 32'(OF_S), 32'(prev_of));
    for (int i = 0; i < N; i++) begin
      eb = b[4*i +: 4] ^ {4{s}};
      chk($sformatf("%s.busy%0d", nm, i), 32'(BUSY), 32'd1);
      chk($sformatf("%s.done%0d", nm, i), 32'(DONE), 32'd0);
      chk($sformatf("%s.add_a%0d", nm, i), 32'(ADD_A), 32'(a[4*i +: 4]));
      chk($sformatf("%s.add_b%0d", nm, i), 32'(ADD_B), 32'(eb));
      if (i == 0) chk({nm, ".cin0"}, 32'(ADD_CIN), 32'(s));
      @(negedge CLK);
    end
    chk({nm, ".done"}, 32'(DONE), 32'd1);
    chk({nm, ".busy_fin"}, 32'(BUSY), 32'd0);
    chk({nm, ".sum"}, 32'(SUM), 32'(esum));
    chk({nm, ".c_msb"}, 32'(C_MSB), 32'(ec));
    chk({nm, ".of_s"}, 32'(OF_S), 32'(eof));
    chk({nm, ".add_fin"}, {27'd0, ADD_CIN, ADD_A}, 32'd0);
    @(negedge CLK);
    chk({nm, ".done_off"}, 32'(DONE), 32'd0);
    chk({nm, ".sum_held"}, 32'(SUM), 32'(esum));
    prev_sum = esum; prev_c = ec; prev_of = eof;
  endtask

  initial begin
    logic [W-1:0] ra, rb, es, es2;
    logic rs, ec, eof, ec2, eof2;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "v_carry_chain"});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "v_pos_ovf"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "v_wrap"});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "v_neg_ovf"});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "v_plain"});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "v_sub_borrow"});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "v_sub_ovf"});
    vecs.push_back('{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, "v_sub_zero"});
`endif

    // Reset, with START asserted to confirm reset priority.
    @(negedge CLK);
    RST = 1'b1; START = 1'b1; A = 16'hABCD; B = 16'h1111;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.busy", 32'(BUSY), 32'd0);
    chk("rst.done", 32'(DONE), 32'd0);
    chk("rst.sum", 32'(SUM), 32'd0);
    chk("rst.flags", {30'd0, C_MSB, OF_S}, 32'd0);
    chk("rst.adder", {27'd0, ADD_CIN, ADD_A}, 32'd0);
    RST = 1'b0; START = 1'b0;

    // Directed vector table.
    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sum, vecs[i].c, vecs[i].of, vecs[i].nm);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (n % 8 == 0) rb = ~ra;
      model(ra, rb, rs, es, ec, eof);
      do_op(ra, rb, rs, es, ec, eof, $sformatf("rnd%0d", n));
    end

    // START held high: a second operation starts only in the IDLE cycle
    // after DONE; operands changed during RUN/FIN are not captured.
    model(16'h0F0F, 16'h0101, 1'b0, es, ec, eof);
    model(16'h2222, 16'h3333, 1'b0, es2, ec2, eof2);
    @(negedge CLK);
    A = 16'h0F0F; B = 16'h0101; sub = 1'b0; START = 1'b1;
    @(negedge CLK);
    A = 16'h2222; B = 16'h3333;
    for (int i = 1; i < N; i++) @(negedge CLK);
    @(negedge CLK);
    chk("hold.done1", 32'(DONE), 32'd1);
    chk("hold.sum1", 32'(SUM), 32'(es));
    @(negedge CLK);
    chk("hold.idle_busy", 32'(BUSY), 32'd0);
    chk("hold.idle_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    chk("hold.accept2", 32'(BUSY), 32'd1);
    for (int i = 0; i < N; i++) @(negedge CLK);
    chk("hold.done2", 32'(DONE), 32'd1);
    chk("hold.sum2", 32'(SUM), 32'(es2));
    @(negedge CLK);
    chk("hold.no_third", 32'(BUSY), 32'd0);

    // Reset on the second RUN cycle aborts the operation.
    @(negedge CLK);
    A = 16'hFFFF; B = 16'h0001; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort.busy", 32'(BUSY), 32'd0);
    chk("abort.sum", 32'(SUM), 32'd0);
    chk("abort.flags", {30'd0, C_MSB, OF_S}, 32'd0);
    chk("abort.adder", {23'd0, ADD_CIN, ADD_B, ADD_A}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < N + 3; i++) begin
        if (DONE) seen++;
        @(negedge CLK);
      end
      chk("abort.no_done", 32'(seen), 32'd0);
    end
    prev_sum = '0; prev_c = 1'b0; prev_of = 1'b0;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
